// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_sequencer                                         |
// | Description : RV32I program counter owner. Issues req/ack fetches,    |
// |               holds each instruction for decode, selects next PC from |
// |               JALR/JAL/branch/pc+4 and traps misaligned targets.      |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  input  logic            instr_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal,
  input  logic [XLEN-1:0] jal_target,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_target,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam logic [XLEN-1:0] c_PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] c_JALR_MASK = ~XLEN'(1);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_addr;
  logic [XLEN-1:0] w_target;
  logic            w_fire;
  logic            w_misaligned;
  logic            w_fetch_done;

  // Next-PC selection with fixed redirect priority and fetch/handshake events
  always_comb begin
    w_target = r_pc + c_PC_STEP;
    if (jalr) begin
      w_target = jalr_target & c_JALR_MASK;
    end else if (jal) begin
      w_target = jal_target;
    end else if (br_taken) begin
      w_target = br_target;
    end
    w_misaligned = |w_target[1:0];
    w_fire       = (r_state == ST_HOLD) && instr_ready;
    w_fetch_done = (r_state == ST_REQ) && imem_ack;
  end

  // Next-state logic; outputs decode from the registered state only
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RST:   w_state_nxt = ST_REQ;
      ST_REQ:   if (imem_ack) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (instr_ready) w_state_nxt = w_misaligned ? ST_FAULT : ST_REQ;
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_RST;
    endcase
  end

  // State register; reset drops any in-flight request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, instruction capture and sticky fault capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      if (w_fetch_done) begin
        r_instr <= imem_rdata;
      end
      if (w_fire) begin
        if (w_misaligned) begin
          r_fault      <= 1'b1;
          r_fault_addr <= w_target;
        end else begin
          r_pc <= w_target;
        end
      end
    end
  end

  assign imem_req    = (r_state == ST_REQ);
  assign instr_valid = (r_state == ST_HOLD);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_sequencer                                      |
// | Description : Directed self-checking bench for fetch_sequencer.       |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jal;
  logic [31:0] jal_target;
  logic        jalr;
  logic [31:0] jalr_target;
  logic        fault;
  logic [31:0] fault_addr;

  int r_checks;
  int r_failures;

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .instr_ready (instr_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jal         (jal),
    .jal_target  (jal_target),
    .jalr        (jalr),
    .jalr_target (jalr_target),
    .fault       (fault),
    .fault_addr  (fault_addr)
  );

  // 10 ns core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_failures++;
      $display("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_redirects();
    br_taken    = 1'b0;
    br_target   = 32'h0;
    jal         = 1'b0;
    jal_target  = 32'h0;
    jalr        = 1'b0;
    jalr_target = 32'h0;
  endtask

  // Reset for two cycles, release at a falling edge, leave the DUT in REQ
  task automatic do_reset(input bit check_state);
    rst_n = 1'b0;
    step();
    step();
    if (check_state) begin
      check("rst_req",        {31'b0, imem_req},    32'h0);
      check("rst_valid",      {31'b0, instr_valid}, 32'h0);
      check("rst_instr",      instr,                32'h0);
      check("rst_pc",         pc,                   32'h0);
      check("rst_fault",      {31'b0, fault},       32'h0);
      check("rst_fault_addr", fault_addr,           32'h0);
    end
    rst_n = 1'b1;
    step();
  endtask

  // From REQ: ack one word, accept it with the given redirects, return at the next state
  task automatic fetch_accept(input logic [31:0] word,
                              input logic i_jalr, input logic [31:0] i_jalr_t,
                              input logic i_jal,  input logic [31:0] i_jal_t,
                              input logic i_br,   input logic [31:0] i_br_t);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    jalr        = i_jalr;
    jalr_target = i_jalr_t;
    jal         = i_jal;
    jal_target  = i_jal_t;
    br_taken    = i_br;
    br_target   = i_br_t;
    step();
    instr_ready = 1'b0;
    clear_redirects();
  endtask

  initial begin
    r_checks    = 0;
    r_failures  = 0;
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    clear_redirects();

    // Sequential fetch with 0-wait memory and decode always ready
    do_reset(1'b1);
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imem_rdata = 32'h1000_0000 | k;
      check($sformatf("seq_req%0d", k),  {31'b0, imem_req}, 32'h1);
      check($sformatf("seq_addr%0d", k), imem_addr, 32'(4 * k));
      step();
      check($sformatf("seq_valid%0d", k), {31'b0, instr_valid}, 32'h1);
      check($sformatf("seq_instr%0d", k), instr, 32'h1000_0000 | k);
      step();
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;

    // Wait states then decode backpressure; redirects ignored while not ready
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wait_req%0d", k),  {31'b0, imem_req}, 32'h1);
      check($sformatf("wait_addr%0d", k), imem_addr, 32'h0);
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    br_taken   = 1'b1;
    br_target  = 32'h0000_0100;
    jal        = 1'b1;
    jal_target = 32'h0000_0200;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("bp_valid%0d", k), {31'b0, instr_valid}, 32'h1);
      check($sformatf("bp_req%0d", k),   {31'b0, imem_req}, 32'h0);
      check($sformatf("bp_instr%0d", k), instr, 32'h0050_0093);
      check($sformatf("bp_pc%0d", k),    pc, 32'h0);
      step();
    end
    clear_redirects();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("bp_next_req",  {31'b0, imem_req}, 32'h1);
    check("bp_next_addr", imem_addr, 32'h4);

    // Reach pc=0x10 via jal, then all redirects together: jalr wins, bit 0 cleared
    fetch_accept(32'h0000_0013, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0);
    check("jal10_addr", imem_addr, 32'h10);
    fetch_accept(32'h0000_0013, 1'b1, 32'h41, 1'b1, 32'h80, 1'b1, 32'h200);
    check("prio_req",  {31'b0, imem_req}, 32'h1);
    check("prio_addr", imem_addr, 32'h40);

    // jal beats branch
    fetch_accept(32'h0000_0013, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h200);
    check("jal_over_br", imem_addr, 32'h300);

    // Taken branch, then jal
    fetch_accept(32'h0000_0013, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
    check("br_addr", imem_addr, 32'h100);
    fetch_accept(32'h0000_0013, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b0, 32'h0);
    check("jal_addr", imem_addr, 32'h0C);

    // Misaligned branch target: sticky fault, no more requests
    fetch_accept(32'h0000_0013, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h102);
    check("mis_fault",      {31'b0, fault}, 32'h1);
    check("mis_fault_addr", fault_addr, 32'h102);
    check("mis_pc",         pc, 32'h0C);
    check("mis_valid",      {31'b0, instr_valid}, 32'h0);
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mis_req%0d", k), {31'b0, imem_req}, 32'h0);
      step();
    end
    check("mis_sticky", {31'b0, fault}, 32'h1);
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    do_reset(1'b1);
    check("mis_rst_fault", {31'b0, fault}, 32'h0);
    check("mis_rst_req",   {31'b0, imem_req}, 32'h1);
    check("mis_rst_addr",  imem_addr, 32'h0);

    // Asynchronous reset in REQ with no ack: request drops before any clock edge
    fetch_accept(32'h0000_0013, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("async_pre_addr", imem_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_drop", {31'b0, imem_req}, 32'h0);
    check("async_pc",       pc, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("async_restart_req",  {31'b0, imem_req}, 32'h1);
    check("async_restart_addr", imem_addr, 32'h0);

    // PC wrap: 0xFFFFFFFC + 4 -> 0 with no fault
    fetch_accept(32'h0000_0013, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    check("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_accept(32'h0000_0013, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("wrap_addr",  imem_addr, 32'h0);
    check("wrap_req",   {31'b0, imem_req}, 32'h1);
    check("wrap_fault", {31'b0, fault}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
    $finish;
  end

endmodule
`default_nettype wire
